dmem_responder: RTL and testbench

Data-memory responder for the 5-stage RISC-V core: the slave end of the core's load/store port. It accepts one request at a time over a valid/ready handshake. It performs byte, halfword or word reads and writes on an internal word array, with programmable wait states. It returns read data or an error over a second valid/ready handshake. It replaces the zero-latency data memory so the pipeline can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 38 +++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and types for the data-memory responder.
package dmem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sign_ext;
   } req_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend and store read-modify-write merge.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   output logic [31:0] rdata_o,
   output logic [31:0] merged_o
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v   = word_i[{lane_i, 3'b000} +: 8];
      half_v   = lane_i[1] ? word_i[31:16] : word_i[15:0];
      rdata_o  = '0;
      merged_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            rdata_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
            merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            rdata_o = {{16{sign_ext_i & half_v[15]}}, half_v};
            if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
            else           merged_o[15:0]  = wdata_i[15:0];
         end
         SZ_WORD: begin
            rdata_o  = word_i;
            merged_o = wdata_i;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte/half/word access to an internal word array with error reporting.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_sign_ext,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);
   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, req_d, cur;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] off, old_word, ld_data, st_word;
   logic [AW-1:0] idx;
   logic        accept, enter_resp, err, mem_we;

   // With zero wait states the response is formed on the accept edge itself,
   // so decode works on the live request in IDLE and the latched one after.
   always_comb begin
      cur      = (state_q == IDLE) ? '{req_write, req_addr, req_wdata, req_size, req_sign_ext} : req_q;
      off      = cur.addr - ADDR_BASE;
      idx      = off[AW+1:2];
      err      = ({1'b0, off} >= SPAN) || (cur.size == 2'b11) ||
                 ((cur.size == SZ_HALF) && cur.addr[0]) ||
                 ((cur.size == SZ_WORD) && (cur.addr[1:0] != 2'b00));
      old_word = mem[idx];
   end

   dmem_lane_align u_align (
      .word_i    (old_word),
      .wdata_i   (cur.wdata),
      .lane_i    (cur.addr[1:0]),
      .size_i    (cur.size),
      .sign_ext_i(cur.sign_ext),
      .rdata_o   (ld_data),
      .merged_o  (st_word)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      enter_resp   = 1'b0;
      accept       = (state_q == IDLE) && req_valid && req_ready_q;
      case (state_q)
         IDLE: if (accept) begin
            req_d = cur;
            if (WAIT_CYCLES == 0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = WAIT_LD;
            end
         end
         WAIT: if (cnt_q == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         RESP: if (resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            resp_rdata_d = '0;
            resp_error_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         resp_valid_d = 1'b1;
         resp_error_d = err;
         resp_rdata_d = (err || cur.write) ? 32'd0 : ld_data;
      end
      req_ready_d = (state_d == IDLE);
      mem_we      = enter_resp && cur.write && !err && !reset;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge clock) begin
      if (mem_we) mem[idx] <= st_word;
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an arithmetic memory model.
module tb_dmem_responder;
   localparam int          DEPTH = 1024;
   localparam int          WAITC = 2;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clock = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_sign_ext = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_rdata;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .ADDR_BASE(BASE)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_sign_ext(req_sign_ext), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error)
   );

   always #5 clock = ~clock;

   int          tests = 0, fails = 0;
   logic [31:0] mdl [DEPTH];
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0, exp_pending = 1'b0;
   logic [31:0] got;
   logic        got_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Expected response from plain address arithmetic and masks.
   function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic se,
                                 output logic [31:0] rd, output logic er);
      longint      off;
      int          nb, sh, ix;
      logic [31:0] mask, v;
      off  = longint'(a) - longint'(BASE);
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      er   = (sz == 2'd3) || (off < 0) || (off >= DEPTH * 4) || ((a % nb) != 0);
      rd   = '0;
      if (!er) begin
         ix   = int'(off / 4);
         sh   = int'(a % 4) * 8;
         mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
         if (w) mdl[ix] = (mdl[ix] & ~(mask << sh)) | ((wd & mask) << sh);
         else begin
            v = (mdl[ix] >> sh) & mask;
            if (se && nb < 4 && v[8*nb-1]) v = v | ~mask;
            rd = v;
         end
      end
   endfunction

   always @(negedge clock) begin
      if (!reset && resp_valid) begin
         chk("resp_pending", {31'd0, exp_pending}, 32'd1);
         chk("resp_error", {31'd0, resp_error}, {31'd0, exp_err});
         chk("resp_rdata", resp_rdata, exp_rdata);
      end
   end

   // Called at a negedge; returns at a negedge after the response handshake.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic se, input int hold,
                         output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clock); n++; end
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
      req_size = sz; req_sign_ext = se;
      model(w, a, wd, sz, se, exp_rdata, exp_err);
      exp_pending = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 40) begin @(negedge clock); n++; end
      chk("latency", 32'(n), 32'(WAITC + 1));
      rd = resp_rdata;
      er = resp_error;
      for (int i = 0; i < hold; i++) begin
         chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
         req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 32'd20;
         req_wdata = 32'hBAD0_BAD0; req_size = 2'b10;
         @(negedge clock);
         chk("resp_valid_held", {31'd0, resp_valid}, 32'd1);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      exp_pending = 1'b0;
      @(negedge clock);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("req_ready_after", {31'd0, req_ready}, 32'd1);
      chk("resp_valid_after", {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic chk_reset_outs(input string nm, input logic rdy);
      chk({nm, "_req_ready"}, {31'd0, req_ready}, {31'd0, rdy});
      chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({nm, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({nm, "_resp_error"}, {31'd0, resp_error}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      repeat (3) @(negedge clock);
      chk_reset_outs("reset", 1'b0);
      reset = 1'b0;
      @(negedge clock);
      chk_reset_outs("post_reset", 1'b1);

      do_req(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, got, got_err);
      chk("st_word_rdata", got, 32'd0);
      chk("st_word_err", {31'd0, got_err}, 32'd0);
      do_req(1'b0, BASE + 32'd8, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      chk("ld_word", got, 32'hDEAD_BEEF);
      do_req(1'b1, BASE + 32'd9, 32'h0000_0080, 2'b00, 1'b0, 0, got, got_err);
      do_req(1'b0, BASE + 32'd8, 32'd0, 2'b10, 1'b1, 0, got, got_err);
      chk("ld_word_after_byte", got, 32'hDEAD_80EF);
      do_req(1'b0, BASE + 32'd9, 32'd0, 2'b00, 1'b1, 0, got, got_err);
      chk("ld_byte_sext", got, 32'hFFFF_FF80);
      do_req(1'b0, BASE + 32'd9, 32'd0, 2'b00, 1'b0, 0, got, got_err);
      chk("ld_byte_zext", got, 32'h0000_0080);
      do_req(1'b0, BASE + 32'd10, 32'd0, 2'b01, 1'b1, 0, got, got_err);
      chk("ld_half_sext", got, 32'hFFFF_DEAD);

      do_req(1'b1, BASE + 32'd12, 32'hCAFE_F00D, 2'b10, 1'b0, 0, got, got_err);
      do_req(1'b1, BASE + 32'd13, 32'h0000_1234, 2'b01, 1'b0, 0, got, got_err);
      chk("misaligned_err", {31'd0, got_err}, 32'd1);
      chk("misaligned_rdata", got, 32'd0);
      do_req(1'b0, BASE + 32'd12, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      chk("ld_after_misaligned", got, 32'hCAFE_F00D);

      do_req(1'b0, BASE + 32'(DEPTH * 4), 32'd0, 2'b10, 1'b0, 0, got, got_err);
      chk("oor_high_err", {31'd0, got_err}, 32'd1);
      do_req(1'b0, BASE - 32'd4, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      chk("oor_low_err", {31'd0, got_err}, 32'd1);
      do_req(1'b0, BASE + 32'd8, 32'd0, 2'b11, 1'b0, 0, got, got_err);
      chk("size11_err", {31'd0, got_err}, 32'd1);

      do_req(1'b1, BASE + 32'd20, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      do_req(1'b0, BASE + 32'd8, 32'd0, 2'b10, 1'b0, 5, got, got_err);
      chk("ld_backpressure", got, 32'hDEAD_80EF);
      do_req(1'b0, BASE + 32'd20, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      chk("stray_req_ignored", got, 32'd0);

      do_req(1'b1, BASE + 32'd16, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 32'd16;
      req_wdata = 32'h1234_5678; req_size = 2'b10;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk_reset_outs("wait_reset", 1'b0);
      reset = 1'b0;
      @(negedge clock);
      chk("wait_reset_ready", {31'd0, req_ready}, 32'd1);
      do_req(1'b0, BASE + 32'd16, 32'd0, 2'b10, 1'b0, 0, got, got_err);
      chk("ld_after_dropped_store", got, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
